// File: rtl/mem_access_pkg.sv
// Shared state encoding, access-size codes and the alignment rule for the memory access unit.
package mem_access_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WRITE = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } state_e;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   // Size code 2'b11 has no legal alignment, so it always reports misaligned.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_B:    return 1'b0;
         SZ_H:    return addr_lo[0];
         SZ_W:    return |addr_lo;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_lane_mux.sv
// Little-endian byte-lane steering: load extract/extend and store merge.
// Purely combinational; no handshake of its own.
module mem_access_unit_lane_mux
   import mem_access_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        uns_i,
   input  logic [31:0] rd_word_i,
   input  logic [31:0] wr_data_i,
   output logic [31:0] ld_data_o,
   output logic [31:0] st_word_o
);

   logic [31:0] shifted;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        ext_bit;

   always_comb begin
      shifted  = rd_word_i >> {addr_lo_i, 3'b000};
      byte_sel = shifted[7:0];
      half_sel = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
      ext_bit  = 1'b0;
      ld_data_o = rd_word_i;
      case (size_i)
         SZ_B: begin
            ext_bit   = ~uns_i & byte_sel[7];
            ld_data_o = {{24{ext_bit}}, byte_sel};
         end
         SZ_H: begin
            ext_bit   = ~uns_i & half_sel[15];
            ld_data_o = {{16{ext_bit}}, half_sel};
         end
         default: ld_data_o = rd_word_i;
      endcase
   end

   // Stores keep the untouched lanes of the word read back from memory.
   always_comb begin
      st_word_o = rd_word_i;
      case (size_i)
         SZ_B: st_word_o[{addr_lo_i, 3'b000} +: 8] = wr_data_i[7:0];
         SZ_H: begin
            if (addr_lo_i[1]) st_word_o[31:16] = wr_data_i[15:0];
            else              st_word_o[15:0]  = wr_data_i[15:0];
         end
         SZ_W:    st_word_o = wr_data_i;
         default: st_word_o = rd_word_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Sub-word load/store sequencer to a word-wide DM: load done 2 cycles after start, store 3, misaligned 1.
// One request at a time; start is only sampled in IDLE and is dropped (not queued) while busy.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int DM_AW = 10,
   parameter int DW    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mem_wr,
   input  logic [1:0]       mem_size,
   input  logic             mem_uns,
   input  logic [31:0]      addr,
   input  logic [DW-1:0]    wdata,
   output logic             busy,
   output logic             done,
   output logic             misalign,
   output logic [DW-1:0]    rdata,
   output logic [DM_AW-1:0] dm_addr,
   output logic [DW-1:0]    dm_din,
   output logic             dm_we,
   input  logic [DW-1:0]    dm_dout
);

   state_e      state_q, state_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] word_q, word_d;
   logic [31:0] rdata_q, rdata_d;

   logic [31:0] mux_rd_word;
   logic [31:0] ld_data;
   logic [31:0] st_word;
   logic        unused_addr_hi;

   assign unused_addr_hi = ^addr_q[31:DM_AW+2];

   // The merge must use the word captured in READ, not whatever DM shows during WRITE.
   assign mux_rd_word = (state_q == ST_WRITE) ? word_q : dm_dout;

   mem_access_unit_lane_mux u_lane_mux (
      .addr_lo_i (addr_q[1:0]),
      .size_i    (size_q),
      .uns_i     (uns_q),
      .rd_word_i (mux_rd_word),
      .wr_data_i (wdata_q),
      .ld_data_o (ld_data),
      .st_word_o (st_word)
   );

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      word_d  = word_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               wr_d    = mem_wr;
               size_d  = mem_size;
               uns_d   = mem_uns;
               addr_d  = addr;
               wdata_d = wdata;
               state_d = is_misaligned(mem_size, addr[1:0]) ? ST_ERR : ST_READ;
            end
         end
         ST_READ: begin
            word_d = dm_dout;
            if (wr_q) begin
               state_d = ST_WRITE;
            end else begin
               rdata_d = ld_data;
               state_d = ST_DONE;
            end
         end
         ST_WRITE: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         ST_ERR:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         wr_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
         rdata_q <= rdata_d;
      end
   end

   // Strobes decode straight from state so an async reset kills dm_we immediately.
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE) || (state_q == ST_ERR);
   assign misalign = (state_q == ST_ERR);
   assign dm_we    = (state_q == ST_WRITE);
   assign dm_din   = (state_q == ST_WRITE) ? st_word : '0;
   assign dm_addr  = addr_q[DM_AW+1:2];
   assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit with a behavioural word-wide DM; scoreboarded request results.
module tb_mem_access_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic        mem_uns;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        misalign;
   logic [31:0] rdata;
   logic [9:0]  dm_addr;
   logic [31:0] dm_din;
   logic        dm_we;
   logic [31:0] dm_dout;

   logic [31:0] dm_mem [0:1023] = '{default: 32'h0};

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      int          lat;
      int          we;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          we_cnt   = 0;
   logic [31:0] last_rd  = 32'h0;

   mem_access_unit #(.DM_AW(10), .DW(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .mem_wr   (mem_wr),
      .mem_size (mem_size),
      .mem_uns  (mem_uns),
      .addr     (addr),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done),
      .misalign (misalign),
      .rdata    (rdata),
      .dm_addr  (dm_addr),
      .dm_din   (dm_din),
      .dm_we    (dm_we),
      .dm_dout  (dm_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign dm_dout = dm_mem[dm_addr];

   always @(posedge clk) begin
      if (dm_we) dm_mem[dm_addr] <= dm_din;
   end

   always @(negedge clk) begin
      if (dm_we) we_cnt = we_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_mis);
      exp_t e;
      int   cyc;
      int   we0;
      e.rdata = exp_rd;
      e.mis   = exp_mis;
      e.lat   = exp_mis ? 1 : (wr ? 3 : 2);
      e.we    = (exp_mis || !wr) ? 0 : 1;
      sb_q.push_back(e);
      @(negedge clk);
      mem_wr = wr; mem_size = sz; mem_uns = uns; addr = a; wdata = wd;
      start = 1'b1;
      we0 = we_cnt;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 1;
      while (!done && cyc < 10) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      e = sb_q.pop_front();
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_lat"}, cyc, e.lat);
      chk({tag, "_mis"}, 32'(misalign), 32'(e.mis));
      chk({tag, "_rdata"}, rdata, e.rdata);
      chk({tag, "_we_cycles"}, we_cnt - we0, e.we);
      if (!wr && !exp_mis) last_rd = exp_rd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cyc;
      int we0;
      rst_n = 1'b0; start = 1'b0; mem_wr = 1'b0; mem_size = 2'b00; mem_uns = 1'b0;
      addr = '0; wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_mis", 32'(misalign), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_we", 32'(dm_we), 32'd0);
      chk("rst_din", dm_din, 32'd0);
      chk("rst_addr", 32'(dm_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // word store then load back
      do_req("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
      chk("sw10_mem", dm_mem[4], 32'hDEADBEEF);
      do_req("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

      // sub-word loads with sign/zero extension
      do_req("lb13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
      do_req("lbu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0);
      do_req("lh10",  1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
      do_req("lhu12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);

      // sub-word stores via read-modify-write
      do_req("sb11", 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF55, last_rd, 1'b0);
      chk("sb11_mem", dm_mem[4], 32'hDEAD55EF);
      do_req("sh12", 1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD1234, last_rd, 1'b0);
      chk("sh12_mem", dm_mem[4], 32'h123455EF);
      do_req("lb11",  1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h00000055, 1'b0);
      do_req("lb10",  1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
      do_req("lh12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h00001234, 1'b0);

      // misaligned requests abort without touching DM or rdata
      do_req("lh11_mis", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, last_rd, 1'b1);
      do_req("sw12_mis", 1'b1, 2'b10, 1'b0, 32'h12, 32'h11111111, last_rd, 1'b1);
      chk("sw12_mis_mem", dm_mem[4], 32'h123455EF);
      do_req("sz11_mis", 1'b1, 2'b11, 1'b0, 32'h10, 32'h22222222, last_rd, 1'b1);
      chk("sz11_mis_mem", dm_mem[4], 32'h123455EF);

      // start held high through a store, then a load accepted the cycle after done
      we0 = we_cnt;
      @(negedge clk);
      mem_wr = 1'b1; mem_size = 2'b10; mem_uns = 1'b0; addr = 32'h30; wdata = 32'h0BADF00D;
      start = 1'b1;
      @(posedge clk);
      #1 cyc = 1;
      while (!done && cyc < 10) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("hold_st_lat", cyc, 3);
      mem_wr = 1'b0;
      @(posedge clk);
      #1;
      chk("hold_idle_busy", 32'(busy), 32'd0);
      chk("hold_idle_done", 32'(done), 32'd0);
      @(posedge clk);
      #1 start = 1'b0;
      chk("hold_ld_busy", 32'(busy), 32'd1);
      cyc = 1;
      while (!done && cyc < 10) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("hold_ld_lat", cyc, 2);
      chk("hold_ld_rdata", rdata, 32'h0BADF00D);
      chk("hold_we_cycles", we_cnt - we0, 1);
      chk("hold_mem", dm_mem[12], 32'h0BADF00D);
      last_rd = 32'h0BADF00D;
      @(posedge clk);
      #1;

      // reset during WRITE of a byte store
      do_req("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5A5A5, last_rd, 1'b0);
      @(negedge clk);
      mem_wr = 1'b1; mem_size = 2'b00; addr = 32'h20; wdata = 32'h0000003C;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1;
      chk("rstw_we_pre", 32'(dm_we), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstw_we", 32'(dm_we), 32'd0);
      chk("rstw_busy", 32'(busy), 32'd0);
      chk("rstw_done", 32'(done), 32'd0);
      chk("rstw_mis", 32'(misalign), 32'd0);
      chk("rstw_rdata", rdata, 32'd0);
      chk("rstw_din", dm_din, 32'd0);
      chk("rstw_addr", 32'(dm_addr), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("rstw_mem", dm_mem[8], 32'hA5A5A5A5);
      rst_n = 1'b1;
      last_rd = 32'h0;
      do_req("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);
      do_req("sb23", 1'b1, 2'b00, 1'b0, 32'h23, 32'h0000003C, last_rd, 1'b0);
      chk("sb23_mem", dm_mem[8], 32'h3CA5A5A5);
      do_req("lbu23", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'h0000003C, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
